// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between cNumReq requesters.
// Requests are arbitrated round-robin and driven to the RAM as a registered
// command; read data is steered back to the issuing requester with a
// fixed-latency tag pipeline that is cRamLat+1 entries deep.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (lowest
// valid index wins, no rotating pointer). The default build is round-robin.
module ram_arbiter #(
    parameter int unsigned cNumReq = 2,
    parameter int unsigned cAddrW  = 5,
    parameter int unsigned cDataW  = 8,
    parameter int unsigned cRamLat = 1
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [cNumReq-1:0]        iReqValid,
    input  logic [cNumReq-1:0]        iReqWEn,
    input  logic [cNumReq*cAddrW-1:0] iReqAddr,
    input  logic [cNumReq*cDataW-1:0] iReqData,
    output logic [cNumReq-1:0]        oReqReady,
    output logic                      oRamEn,
    output logic                      oRamWEn,
    output logic [cAddrW-1:0]         oRamAddr,
    output logic [cDataW-1:0]         oRamData,
    input  logic                      iRamDv,
    input  logic [cAddrW-1:0]         iRamAddr,
    input  logic [cDataW-1:0]         iRamData,
    output logic [cNumReq-1:0]        oRspValid,
    output logic [cAddrW-1:0]         oRspAddr,
    output logic [cDataW-1:0]         oRspData,
    output logic                      oErr
);

    localparam int unsigned cIdxW     = (cNumReq > 1) ? $clog2(cNumReq) : 1;
    localparam int unsigned cTagDepth = cRamLat + 1;
    localparam int unsigned cTagLast  = cRamLat;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [cNumReq-1:0] grant_c;
    logic [cIdxW-1:0]   gnt_idx_c;
    logic [cIdxW-1:0]   cand_c;
    logic               xfer_c;
    logic               gnt_wen_c;
    logic [cAddrW-1:0]  gnt_addr_c;
    logic [cDataW-1:0]  gnt_data_c;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-indexed valid requester always wins.
    always_comb begin
        grant_c   = '0;
        gnt_idx_c = '0;
        cand_c    = '0;
        for (int unsigned k = 0; k < cNumReq; k++) begin
            cand_c = cIdxW'(k);
            if ((grant_c == '0) && iReqValid[cand_c]) begin
                grant_c[cand_c] = 1'b1;
                gnt_idx_c       = cand_c;
            end
        end
    end
`else
    logic [cIdxW-1:0] rr_ptr_q;
    logic [cIdxW-1:0] rr_ptr_d;

    // Round-robin: search from rr_ptr_q upward, wrapping modulo cNumReq.
    always_comb begin
        grant_c   = '0;
        gnt_idx_c = '0;
        cand_c    = '0;
        for (int unsigned k = 0; k < cNumReq; k++) begin
            cand_c = cIdxW'((32'(rr_ptr_q) + k) % cNumReq);
            if ((grant_c == '0) && iReqValid[cand_c]) begin
                grant_c[cand_c] = 1'b1;
                gnt_idx_c       = cand_c;
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer_c) begin
            if ((32'(gnt_idx_c) + 32'd1) >= cNumReq) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx_c + cIdxW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Grant is only offered outside reset so every output reads 0 in reset.
    assign oReqReady = iRst ? '0 : grant_c;
    assign xfer_c    = (|grant_c) & ~iRst;

    // Select the granted requester's command fields.
    always_comb begin
        gnt_wen_c  = iReqWEn[gnt_idx_c];
        gnt_addr_c = iReqAddr[32'(gnt_idx_c) * cAddrW +: cAddrW];
        gnt_data_c = iReqData[32'(gnt_idx_c) * cDataW +: cDataW];
    end

    // ------------------------------------------------------------------
    // Registered RAM command
    // ------------------------------------------------------------------
    logic              ram_en_q,   ram_en_d;
    logic              ram_wen_q,  ram_wen_d;
    logic [cAddrW-1:0] ram_addr_q, ram_addr_d;
    logic [cDataW-1:0] ram_data_q, ram_data_d;

    // Issue the granted command next cycle; address and data hold when idle.
    always_comb begin
        ram_en_d   = xfer_c;
        ram_wen_d  = xfer_c & gnt_wen_c;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        if (xfer_c) begin
            ram_addr_d = gnt_addr_c;
            ram_data_d = gnt_data_c;
        end
    end

    // Command register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ram_en_q   <= 1'b0;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            ram_en_q   <= ram_en_d;
            ram_wen_q  <= ram_wen_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign oRamEn   = ram_en_q;
    assign oRamWEn  = ram_wen_q;
    assign oRamAddr = ram_addr_q;
    assign oRamData = ram_data_q;

    // ------------------------------------------------------------------
    // Tag pipeline: one entry per cycle, valid only for read transfers
    // ------------------------------------------------------------------
    logic             tag_v_q  [cTagDepth];
    logic             tag_v_d  [cTagDepth];
    logic [cIdxW-1:0] tag_id_q [cTagDepth];
    logic [cIdxW-1:0] tag_id_d [cTagDepth];

    // Push the current transfer's tag and shift older tags toward the output.
    always_comb begin
        tag_v_d[0]  = xfer_c & ~gnt_wen_c;
        tag_id_d[0] = gnt_idx_c;
        for (int unsigned i = 1; i < cTagDepth; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    // Tag shift register; cleared on reset so in-flight reads are dropped.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int unsigned i = 0; i < cTagDepth; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_id_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < cTagDepth; i++) begin
                tag_v_q[i]  <= tag_v_d[i];
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing and protocol checking
    // ------------------------------------------------------------------
    logic               tag_out_v_c;
    logic               rsp_hit_c;
    logic [cNumReq-1:0] rsp_valid_c;
    logic               err_q, err_d;

    assign tag_out_v_c = tag_v_q[cTagLast];

    // Steer RAM return data to the tagged requester when tag and dv agree.
    always_comb begin
        rsp_valid_c = '0;
        rsp_hit_c   = iRamDv & tag_out_v_c & ~iRst;
        if (rsp_hit_c) begin
            rsp_valid_c[tag_id_q[cTagLast]] = 1'b1;
        end
    end

    assign oRspValid = rsp_valid_c;
    assign oRspAddr  = rsp_hit_c ? iRamAddr : '0;
    assign oRspData  = rsp_hit_c ? iRamData : '0;

    // Any disagreement between the RAM data-valid and the expected tag is sticky.
    always_comb begin
        err_d = err_q | (iRamDv ^ tag_out_v_c);
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign oErr = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter with a behavioural RAM model.
module tb_ram_arbiter;

    localparam int N   = 2;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int LAT = 1;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_wen;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              ram_en;
    logic              ram_wen;
    logic [AW-1:0]     ram_addr_o;
    logic [DW-1:0]     ram_data_o;
    logic              ram_dv;
    logic [AW-1:0]     ram_addr_i;
    logic [DW-1:0]     ram_data_i;
    logic [N-1:0]      rsp_valid;
    logic [AW-1:0]     rsp_addr;
    logic [DW-1:0]     rsp_data;
    logic              err;

    ram_arbiter #(.cNumReq(N), .cAddrW(AW), .cDataW(DW), .cRamLat(LAT)) dut (
        .iClk(clk), .iRst(rst),
        .iReqValid(req_valid), .iReqWEn(req_wen), .iReqAddr(req_addr), .iReqData(req_data),
        .oReqReady(req_ready),
        .oRamEn(ram_en), .oRamWEn(ram_wen), .oRamAddr(ram_addr_o), .oRamData(ram_data_o),
        .iRamDv(ram_dv), .iRamAddr(ram_addr_i), .iRamData(ram_data_i),
        .oRspValid(rsp_valid), .oRspAddr(rsp_addr), .oRspData(rsp_data),
        .oErr(err)
    );

    typedef struct {
        bit            bubble;
        bit            wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_rsp_t;

    op_t           op_q [N][$];
    bit            showing [N];
    logic [N-1:0]  gnt_seen;
    exp_rsp_t      exp_q [$];
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] ram_mem [32];
    int            ref_ptr;
    bit            exp_cmd_v, exp_cmd_wen;
    logic [AW-1:0] exp_cmd_addr;
    logic [DW-1:0] exp_cmd_data;
    bit            exp_err;
    bit            inj_dv;
    int            cyc;
    int            xfer_log [$];
    logic [N-1:0]  gnt_hist [$];
    int            total;
    int            bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester drivers: present queue heads, retire them on grant or after a bubble cycle.
    initial begin
        logic [N-1:0]    v, w;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        forever begin
            @(posedge clk);
            #1;
            v = '0; w = '0; a = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    op_q[i].delete();
                end else if (showing[i] && (op_q[i][0].bubble || gnt_seen[i])) begin
                    void'(op_q[i].pop_front());
                end
                showing[i] = 1'b0;
                if (!rst && op_q[i].size() > 0) begin
                    showing[i]      = 1'b1;
                    v[i]            = !op_q[i][0].bubble;
                    w[i]            = op_q[i][0].wen;
                    a[i*AW +: AW]   = op_q[i][0].addr;
                    d[i*DW +: DW]   = op_q[i][0].data;
                end
            end
            gnt_seen  = '0;
            req_valid = v;
            req_wen   = w;
            req_addr  = a;
            req_data  = d;
        end
    end

    // Behavioural write-first RAM returning read data LAT cycles after the command.
    initial begin
        logic          cap_en, cap_wen;
        logic [AW-1:0] cap_a;
        logic [DW-1:0] cap_d;
        logic          st_v [LAT];
        logic [AW-1:0] st_a [LAT];
        logic [DW-1:0] st_d [LAT];
        for (int i = 0; i < LAT; i++) begin
            st_v[i] = 1'b0; st_a[i] = '0; st_d[i] = '0;
        end
        forever begin
            @(negedge clk);
            cap_en = ram_en; cap_wen = ram_wen; cap_a = ram_addr_o; cap_d = ram_data_o;
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < LAT; i++) st_v[i] = 1'b0;
            end else begin
                if (cap_en && cap_wen) ram_mem[cap_a] = cap_d;
                for (int i = LAT - 1; i > 0; i--) begin
                    st_v[i] = st_v[i-1]; st_a[i] = st_a[i-1]; st_d[i] = st_d[i-1];
                end
                st_v[0] = cap_en && !cap_wen;
                st_a[0] = cap_a;
                st_d[0] = ram_mem[cap_a];
            end
            #1;
            ram_dv     = st_v[LAT-1] | inj_dv;
            ram_addr_i = st_a[LAT-1];
            ram_data_i = st_d[LAT-1];
        end
    end

    // Monitor: reference grant/command/response/error model and scoreboard.
    initial begin
        logic [N-1:0]  eg;
        int            g;
        exp_rsp_t      e;
        bit            due_now;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            w;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", 64'({req_ready, ram_en, ram_wen, ram_addr_o, ram_data_o,
                                           rsp_valid, rsp_addr, rsp_data, err}), 64'(0));
                ref_ptr   = 0;
                exp_q.delete();
                exp_cmd_v = 1'b0;
                exp_err   = 1'b0;
                gnt_seen  = '0;
            end else begin
                eg = '0;
                g  = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(ref_ptr + k) % N]) g = (ref_ptr + k) % N;
                end
                if (g >= 0) eg[g] = 1'b1;
                chk("grant", 64'(req_ready), 64'(eg));

                chk("ram_en", 64'(ram_en), 64'(exp_cmd_v));
                if (exp_cmd_v) begin
                    chk("ram_wen", 64'(ram_wen), 64'(exp_cmd_wen));
                    chk("ram_addr", 64'(ram_addr_o), 64'(exp_cmd_addr));
                    chk("ram_data", 64'(ram_data_o), 64'(exp_cmd_data));
                end else begin
                    chk("ram_wen_idle", 64'(ram_wen), 64'(0));
                end

                due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                if (rsp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rsp_unexpected: got valid=%b with no read outstanding (cycle %0d)",
                                 rsp_valid, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 64'(rsp_valid), 64'(1) << e.id);
                        chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                        chk("rsp_data", 64'(rsp_data), 64'(e.data));
                        chk("rsp_latency", 64'(cyc), 64'(e.due));
                    end
                end else if (due_now) begin
                    total++; bad++;
                    $display("FAIL rsp_missing: got none expected id=%0d addr=%0h data=%0h (cycle %0d)",
                             exp_q[0].id, exp_q[0].addr, exp_q[0].data, cyc);
                    void'(exp_q.pop_front());
                end

                chk("err", 64'(err), 64'(exp_err));
                if (ram_dv != due_now) exp_err = 1'b1;

                gnt_seen  = eg;
                exp_cmd_v = 1'b0;
                if (g >= 0) begin
                    xfer_log.push_back(cyc);
                    gnt_hist.push_back(req_ready);
                    w = req_wen[g];
                    a = req_addr[g*AW +: AW];
                    d = req_data[g*DW +: DW];
                    exp_cmd_v = 1'b1; exp_cmd_wen = w; exp_cmd_addr = a; exp_cmd_data = d;
                    if (w) ref_mem[a] = d;
                    else   exp_q.push_back('{id: g, addr: a, data: ref_mem[a], due: cyc + LAT + 1});
`ifndef RAM_ARB_FIXED_PRIO_EN
                    ref_ptr = (g + 1) % N;
`endif
                end
            end
        end
    end

    function automatic bit busy();
        bit b;
        b = (exp_q.size() > 0);
        for (int i = 0; i < N; i++) if (op_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy() && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++; bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({req_ready, ram_en, ram_wen, ram_addr_o, ram_data_o,
                                        rsp_valid, rsp_addr, rsp_data, err}), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic push_op(input int r, input bit bub, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.bubble = bub; o.wen = w; o.addr = a; o.data = d;
        op_q[r].push_back(o);
    endtask

    initial begin
        logic [N-1:0] exp_seq [4];
        int n;
        total = 0; bad = 0;
        rst = 1'b1; inj_dv = 1'b0;
        req_valid = '0; req_wen = '0; req_addr = '0; req_data = '0;
        ram_dv = 1'b0; ram_addr_i = '0; ram_data_i = '0;
        gnt_seen = '0; ref_ptr = 0; exp_cmd_v = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < N; i++) showing[i] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = '0; ram_mem[i] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);

        // Write sweep by requester 0.
        xfer_log.delete();
        for (int i = 0; i < 32; i++) push_op(0, 1'b0, 1'b1, AW'(i), DW'(10 + i));
        wait_idle("write_sweep");
        chk("sweep_count", 64'(xfer_log.size()), 64'(32));
        if (xfer_log.size() == 32) chk("sweep_span", 64'(xfer_log[31] - xfer_log[0]), 64'(31));

        // Read-back routing to requester 1.
        for (int i = 0; i < 32; i++) push_op(1, 1'b0, 1'b0, AW'(i), '0);
        wait_idle("read_routing");

        // Contention from reset.
        do_reset();
        gnt_hist.delete();
        push_op(0, 1'b0, 1'b0, AW'(5), '0);
        push_op(0, 1'b0, 1'b0, AW'(5), '0);
        push_op(1, 1'b0, 1'b0, AW'(7), '0);
        push_op(1, 1'b0, 1'b0, AW'(7), '0);
        wait_idle("contention");
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_seq = '{2'b01, 2'b01, 2'b10, 2'b10};
`else
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        chk("contention_count", 64'(gnt_hist.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < gnt_hist.size()) chk("contention_grant", 64'(gnt_hist[i]), 64'(exp_seq[i]));

        // Read immediately after write to the same address.
        push_op(0, 1'b0, 1'b1, AW'(3), 8'hA5);
        push_op(1, 1'b1, 1'b0, '0, '0);
        push_op(1, 1'b0, 1'b0, AW'(3), '0);
        wait_idle("raw");
        chk("raw_mem", 64'(ref_mem[3]), 64'(8'hA5));

        // Asynchronous reset with a read in flight, then pointer restart.
        xfer_log.delete();
        push_op(0, 1'b0, 1'b0, AW'(9), '0);
        n = 0;
        while (xfer_log.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL inflight_timeout: no transfer after %0d cycles, required one", n);
        end
        do_reset();
        gnt_hist.delete();
        @(negedge clk);
        push_op(0, 1'b0, 1'b0, AW'(1), '0);
        push_op(1, 1'b0, 1'b0, AW'(2), '0);
        wait_idle("reset_restart");
        if (gnt_hist.size() > 0) chk("rr_restart", 64'(gnt_hist[0]), 64'(2'b01));
        else begin
            total++; bad++;
            $display("FAIL rr_restart: got no grant, required 01");
        end

        // Protocol error: data-valid with nothing outstanding.
        @(negedge clk);
        inj_dv = 1'b1;
        @(negedge clk);
        inj_dv = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'(1));
        do_reset();
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'(0));

        // Randomised mixed traffic.
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < 60; i++) begin
                push_op(r, ($urandom % 4) == 0, ($urandom % 2) == 1,
                        AW'($urandom), DW'($urandom));
            end
        end
        wait_idle("random");
        chk("final_err", 64'(err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port ram block between cNumReq requesters, for example a weight loader, an activation loader and a debug port of the int8 MAC array.
- Arbitrates read and write requests round-robin and drives the ram command interface (en, wEn, addr, data).
- Routes each read result (dv, data, addr) back to the requester that issued it, using a fixed-latency tag pipeline.

Parameters:
- cNumReq, 2, number of requesters (2..4).
- cAddrW, 5, ram address width (depth 32).
- cDataW, 8, ram data width.
- cRamLat, 1, ram read latency in cycles, from the command registered at the ram input to oRam.dv.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  asynchronous reset, active-high.
- iReqValid  in  cNumReq  per-requester request valid.
- iReqWEn  in  cNumReq  1 = write, 0 = read.
- iReqAddr  in  cNumReq*cAddrW  packed addresses; requester i occupies slice i.
- iReqData  in  cNumReq*cDataW  packed write data.
- oReqReady  out  cNumReq  one-hot grant; transfer occurs when valid and ready are both high.
- oRamEn  out  1  ram enable.
- oRamWEn  out  1  ram write enable.
- oRamAddr  out  cAddrW  ram address.
- oRamData  out  cDataW  ram write data.
- iRamDv  in  1  ram read data valid.
- iRamAddr  in  cAddrW  ram read address echo.
- iRamData  in  cDataW  ram read data.
- oRspValid  out  cNumReq  one-hot read response strobe.
- oRspAddr  out  cAddrW  response address.
- oRspData  out  cDataW  response data.
- oErr  out  1  sticky protocol error.

Behaviour:
- Reset (async, iRst = 1):
  - All outputs go to 0.
  - rrPtr goes to 0.
  - Tag pipeline is cleared.
  - Any in-flight reads are discarded; no response is issued for them after reset.
- Grant (combinational from iReqValid and rrPtr):
  - Search starts at index rrPtr and wraps modulo cNumReq; the first valid requester is granted.
  - oReqReady equals the grant; it is all-zero when no request is valid.
  - Requests are never blocked for any other reason.
  - Requesters must hold valid, wEn, addr and data stable until they see ready.
- rrPtr update: on a transfer by requester g, rrPtr becomes (g+1) mod cNumReq. With no transfer it is unchanged.
- Command stage (registered):
  - In the cycle after a transfer: oRamEn = 1, oRamWEn = the granted iReqWEn, oRamAddr and oRamData = the granted slices.
  - With no transfer: oRamEn = 0, oRamWEn = 0; addr and data hold their previous values.
  - Throughput: one command per cycle.
- Tag pipeline:
  - Shift register of depth cRamLat+1, each entry {valid, id}.
  - An entry is pushed with valid = 1 for each read transfer and valid = 0 otherwise.
- Response stage (combinational from the ram return):
  - When iRamDv = 1 and the tag pipeline output is valid: oRspValid[id] = 1, oRspAddr = iRamAddr, oRspData = iRamData.
  - Total read latency, from the request transfer to oRspValid: cRamLat + 1 cycles.
- Writes produce no response.
- Read after write to the same address, issued back-to-back: returns the new data. The ram is write-first; no bypass is needed.
- Error conditions, all setting oErr (cleared only by iRst):
  - iRamDv = 1 while the tag output is invalid.
  - Tag output valid while iRamDv = 0.
  - On a mismatch the response is suppressed.
- Simultaneous valid from all requesters: grants rotate 0, 1, …, N-1, 0; no requester waits more than cNumReq-1 transfers.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest valid index always wins.
  - rrPtr is removed; requester 0 can starve the others.
- Undefined: round-robin as described under Behaviour.
- Response routing, latency and error logic are identical in both builds.

Test Plan:
- Write sweep:
  - Stimulus: req0 writes addr 0..31 with data 10..41, one per cycle.
  - Required: 32 transfers in 32 consecutive cycles; oRamEn = 1 and oRamWEn = 1 one cycle after each transfer; oErr = 0.
- Read routing:
  - Stimulus: req1 reads addr 0..31 after the write sweep.
  - Required: oRspValid = 2'b10 with data 10..41, each 2 cycles (cRamLat = 1) after its transfer; oRspValid[0] never set.
- Contention:
  - Stimulus: req0 and req1 both hold valid reads of addr 5 and addr 7 from reset.
  - Required: grants are 01, 10, 01, 10; responses alternate with data 15 and 17 routed correctly.
- Read after write:
  - Stimulus: req0 writes addr 3 = 8'hA5; in the next cycle req1 reads addr 3.
  - Required: oRspValid[1] with data 8'hA5.
- Async reset:
  - Stimulus: assert iRst mid-cycle while a read is in flight.
  - Required: all outputs 0 immediately; no oRspValid after release; rrPtr restarts at 0.
- Protocol error:
  - Stimulus: force iRamDv = 1 with no read outstanding.
  - Required: oErr = 1 and held until iRst; no oRspValid bit set.
